// File: rtl/i2c_pkg.sv
// +------------------------------------------------------------------+
// | i2c_pkg : shared I2C target types and constants                  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package i2c_pkg;

  localparam int         I2C_ADDR_W        = 7;
  localparam int         I2C_BYTE_W        = 8;
  localparam logic       I2C_ACK           = 1'b0;
  localparam logic       I2C_NACK          = 1'b1;
  localparam logic [6:0] LCD_BACKPACK_ADDR = 7'h27;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR        = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD        = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_tgt_state_t;

  // The general-call address is never claimed by this target.
  function automatic logic addr_match(input logic [I2C_ADDR_W-1:0] addr,
                                      input logic [I2C_ADDR_W-1:0] tgt);
    return (addr == tgt) && (addr != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_bus_cond.sv
// +------------------------------------------------------------------+
// | i2c_bus_cond : SCL/SDA synchronizers, optional majority filter   |
// | (LCD_I2C_TGT_GLITCH_FILTER_EN), edge and START/STOP pulses.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module i2c_bus_cond (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_lvl, sda_lvl;
  logic       scl_prev_q, sda_prev_q;

  // Reset to the idle-bus level so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
    end
  end

`ifdef LCD_I2C_TGT_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
      sda_filt_q <= maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end
  end

  assign scl_lvl = scl_filt_q;
  assign sda_lvl = sda_filt_q;
`else
  assign scl_lvl = scl_sync_q[1];
  assign sda_lvl = sda_sync_q[1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
      sda_o      <= 1'b1;
    end else begin
      scl_prev_q <= scl_lvl;
      sda_prev_q <= sda_lvl;
      scl_rise_o <= scl_lvl & ~scl_prev_q;
      scl_fall_o <= ~scl_lvl & scl_prev_q;
      start_o    <= scl_lvl & scl_prev_q & ~sda_lvl & sda_prev_q;
      stop_o     <= scl_lvl & scl_prev_q & sda_lvl & ~sda_prev_q;
      sda_o      <= sda_lvl;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_i2c_target.sv
// +------------------------------------------------------------------+
// | lcd_i2c_target : PCF8574-style I2C target for LCD backpacks.     |
// | Optional macro LCD_I2C_TGT_GLITCH_FILTER_EN (in i2c_bus_cond).   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module lcd_i2c_target
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TGT_ADDR   = LCD_BACKPACK_ADDR,
  parameter logic [I2C_BYTE_W-1:0] PORT_RESET = 8'hFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  output logic [I2C_BYTE_W-1:0] port_q,
  output logic [I2C_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_cond u_bus_cond (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl),
    .sda_i      (sda_in),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det),
    .sda_o      (sda_s)
  );

  i2c_tgt_state_t          state_q;
  logic [3:0]              bit_cnt_q;
  logic [I2C_BYTE_W-1:0]   shift_q;
  logic                    rw_q;
  logic [I2C_BYTE_W-1:0]   byte_d;

  assign byte_d = {shift_q[I2C_BYTE_W-2:0], sda_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      port_q    <= PORT_RESET;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (stop_det) begin
        state_q   <= ST_IDLE;
        bit_cnt_q <= 4'd0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else if (start_det) begin
        // Any partial byte is dropped; busy is re-evaluated at the address.
        state_q   <= ST_ADDR;
        bit_cnt_q <= 4'd0;
        sda_oe    <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_q   <= byte_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (addr_match(byte_d[7:1], TGT_ADDR)) begin
                  state_q <= ST_ADDR_ACK;
                  busy    <= 1'b1;
                  rw_q    <= byte_d[0];
                end else begin
                  state_q <= ST_WAIT_STOP;
                  busy    <= 1'b0;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_WR_ACK: begin
            // Count 8 marks the fall that opens the ACK slot, 0 the one closing it.
            if (scl_rise) begin
              bit_cnt_q <= 4'd0;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe <= ~I2C_ACK;
              end else if ((state_q == ST_ADDR_ACK) && rw_q) begin
                state_q <= ST_RD;
                shift_q <= port_q;
                sda_oe  <= ~port_q[7];
              end else begin
                state_q <= ST_WR;
                sda_oe  <= 1'b0;
              end
            end
          end
          ST_WR: begin
            if (scl_rise) begin
              shift_q   <= byte_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                rx_data  <= byte_d;
                port_q   <= byte_d;
                rx_valid <= 1'b1;
                state_q  <= ST_WR_ACK;
              end
            end
          end
          ST_RD: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                sda_oe  <= 1'b0;
                state_q <= ST_RD_ACK;
              end else begin
                sda_oe  <= ~shift_q[6];
                shift_q <= {shift_q[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              bit_cnt_q <= 4'd0;
              if (sda_s == I2C_NACK) state_q <= ST_WAIT_STOP;
            end else if (scl_fall && (bit_cnt_q == 4'd0)) begin
              state_q <= ST_RD;
              shift_q <= port_q;
              sda_oe  <= ~port_q[7];
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_i2c_target.sv
// +------------------------------------------------------------------+
// | tb_lcd_i2c_target : directed bench with a bit-banged I2C master. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_lcd_i2c_target;

  localparam int T = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] port_q, rx_data;
  logic       rx_valid, busy;

  int checks = 0;
  int errors = 0;
  int rxv_cnt = 0;
  int oe_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  lcd_i2c_target dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl_m),
    .sda_in   (sda_line),
    .sda_oe   (sda_oe),
    .port_q   (port_q),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt <= rxv_cnt + 1;
    if (sda_oe)   oe_cnt  <= oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; #T;
    scl_m = 1'b1; #T;
    sda_m = 1'b0; #T;
    scl_m = 1'b0; #T;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; #T;
    scl_m = 1'b1; #T;
    sda_m = 1'b1; #T;
  endtask

  task automatic write_bit(input logic b, input logic glitch);
    sda_m = b;
    if (glitch) begin
      @(negedge clk); scl_m = 1'b1;
      @(negedge clk); scl_m = 1'b0;
      #(T - 20);
    end else begin
      #T;
    end
    scl_m = 1'b1; #(2*T);
    scl_m = 1'b0; #T;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #T;
    scl_m = 1'b1; #T;
    b = sda_line; #T;
    scl_m = 1'b0; #T;
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic ack_to_send, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(ack_to_send, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         base;

    #100;
    rst = 1'b0;
    #50;
    chk("reset_sda_oe",   sda_oe,   1'b0);
    chk("reset_port_q",   port_q,   8'hFF);
    chk("reset_rx_data",  rx_data,  8'h00);
    chk("reset_rx_valid", rx_valid, 1'b0);
    chk("reset_busy",     busy,     1'b0);

    // Wrong address and general call: never acknowledged, nothing latched.
    base = rxv_cnt;
    chk("oe_idle_count", oe_cnt, 0);
    i2c_start();
    write_byte(8'h40, -1, ack); chk("wrong_addr_nack", ack, 1'b1);
    chk("wrong_addr_busy", busy, 1'b0);
    write_byte(8'h55, -1, ack); chk("wrong_data_nack", ack, 1'b1);
    i2c_stop();
    i2c_start();
    write_byte(8'h00, -1, ack); chk("gencall_nack", ack, 1'b1);
    i2c_stop();
    #100;
    chk("wrong_oe_count", oe_cnt, 0);
    chk("wrong_rxv_count", rxv_cnt - base, 0);
    chk("wrong_port_q", port_q, 8'hFF);

    // Plain write of one byte.
    base = rxv_cnt;
    i2c_start();
    write_byte(8'h4E, -1, ack); chk("wr_addr_ack", ack, 1'b0);
    chk("wr_busy", busy, 1'b1);
    write_byte(8'h0C, -1, ack); chk("wr_data_ack", ack, 1'b0);
    i2c_stop();
    #100;
    chk("wr_busy_after_stop", busy, 1'b0);
    chk("wr_port_q", port_q, 8'h0C);
    chk("wr_rx_data", rx_data, 8'h0C);
    chk("wr_rxv_count", rxv_cnt - base, 1);

    // Write 0xA5, then read it back twice.
    i2c_start();
    write_byte(8'h4E, -1, ack);
    write_byte(8'hA5, -1, ack); chk("rd_setup_ack", ack, 1'b0);
    i2c_stop();
    i2c_start();
    write_byte(8'h4F, -1, ack); chk("rd_addr_ack", ack, 1'b0);
    read_byte(1'b0, d); chk("rd_byte0", d, 8'hA5);
    read_byte(1'b1, d); chk("rd_byte1", d, 8'hA5);
    chk("rd_oe_after_nack", sda_oe, 1'b0);
    i2c_stop();
    #100;
    chk("rd_busy_after_stop", busy, 1'b0);

    // Repeated START drops a partial byte.
    base = rxv_cnt;
    i2c_start();
    write_byte(8'h4E, -1, ack);
    write_bit(1'b0, 1'b0); write_bit(1'b1, 1'b0); write_bit(1'b0, 1'b0);
    i2c_start();
    chk("rs_busy_held", busy, 1'b1);
    write_byte(8'h4E, -1, ack); chk("rs_addr_ack", ack, 1'b0);
    write_byte(8'h3C, -1, ack); chk("rs_data_ack", ack, 1'b0);
    i2c_stop();
    #100;
    chk("rs_rxv_count", rxv_cnt - base, 1);
    chk("rs_rx_data", rx_data, 8'h3C);
    chk("rs_port_q", port_q, 8'h3C);

    // Reset while the target is holding the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(((8'h4E >> i) & 8'h01) != 0, 1'b0);
    sda_m = 1'b1; #T;
    chk("mid_ack_oe_before", sda_oe, 1'b1);
    rst = 1'b1; #1;
    chk("mid_ack_oe_reset", sda_oe, 1'b0);
    chk("mid_ack_port_q", port_q, 8'hFF);
    chk("mid_ack_busy", busy, 1'b0);
    #29;
    rst = 1'b0; #T;
    scl_m = 1'b1; #(2*T);
    i2c_start();
    write_byte(8'h4E, -1, ack); chk("post_rst_addr_ack", ack, 1'b0);
    write_byte(8'h0C, -1, ack);
    i2c_stop();
    #100;
    chk("post_rst_port_q", port_q, 8'h0C);

`ifdef LCD_I2C_TGT_GLITCH_FILTER_EN
    // A 1-clk SCL spike inside a data bit must not add a bit.
    base = rxv_cnt;
    i2c_start();
    write_byte(8'h4E, -1, ack);
    write_byte(8'h0C, 3, ack); chk("glitch_data_ack", ack, 1'b0);
    i2c_stop();
    #100;
    chk("glitch_rx_data", rx_data, 8'h0C);
    chk("glitch_rxv_count", rxv_cnt - base, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
